mem_xfer_ctrl: RTL and testbench

Memory-transfer sequencer for the MAR/MDR pair. Accepts single-word read or write requests from the control unit and drives the MAR and MDR load enables and the MDR read-select. Runs the memory read/write strobe handshake with wait states, then signals completion. Sits between the control unit, the MAR/MDR registers and the memory port; it carries no data itself.

---
 rtl/mem_xfer_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_xfer_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_xfer_ctrl.sv
// MAR/MDR memory-transfer sequencer with strobe/ready handshake.
// Optional wait-state timeout: define MEM_XFER_TIMEOUT_EN.
module mem_xfer_ctrl #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic              mem_ready,
  output logic              MARin,
  output logic              MDRin,
  output logic              read,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WAIT_W-1:0] last_wait
);

  if (MAX_WAIT > (1 << WAIT_W) - 1) begin : g_bad_max_wait
    $error("MAX_WAIT does not fit in WAIT_W bits");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD_MAR,
    LOAD_MDR,
    RD_WAIT,
    WR_WAIT,
    DONE,
    ERR
  } state_t;

  localparam logic [WAIT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic              op_wr;
  logic [WAIT_W-1:0] cnt;
  logic [WAIT_W-1:0] cnt_inc;
  logic              mdr_q;
  logic              tmo;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

`ifdef MEM_XFER_TIMEOUT_EN
  logic err_q;
  assign tmo = (cnt == WAIT_W'(MAX_WAIT));
  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // Read capture is Mealy so MDR latches on the edge that sees ready.
  assign MDRin = mdr_q | ((state == RD_WAIT) & mem_ready);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      cnt       <= '0;
      last_wait <= '0;
      MARin     <= 1'b0;
      mdr_q     <= 1'b0;
      read      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MEM_XFER_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      MARin  <= 1'b0;
      mdr_q  <= 1'b0;
      read   <= 1'b0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef MEM_XFER_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (req_rd || req_wr) begin
            state <= LOAD_MAR;
            op_wr <= ~req_rd;
            MARin <= 1'b1;
            busy  <= 1'b1;
          end
        end
        LOAD_MAR: begin
          busy <= 1'b1;
          if (op_wr) begin
            state <= LOAD_MDR;
            mdr_q <= 1'b1;
          end else begin
            state  <= RD_WAIT;
            mem_rd <= 1'b1;
            read   <= 1'b1;
          end
        end
        LOAD_MDR: begin
          state  <= WR_WAIT;
          mem_wr <= 1'b1;
          busy   <= 1'b1;
        end
        RD_WAIT, WR_WAIT: begin
          if (mem_ready) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (tmo) begin
            state <= ERR;
`ifdef MEM_XFER_TIMEOUT_EN
            err_q <= 1'b1;
`endif
          end else begin
            cnt    <= cnt_inc;
            busy   <= 1'b1;
            mem_rd <= (state == RD_WAIT);
            read   <= (state == RD_WAIT);
            mem_wr <= (state == WR_WAIT);
          end
        end
        DONE, ERR: begin
          state     <= IDLE;
          last_wait <= cnt;
          cnt       <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Directed self-checking bench for mem_xfer_ctrl.
// Timeout scenario compiled in with MEM_XFER_TIMEOUT_EN.
module tb_mem_xfer_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       req_rd;
  logic       req_wr;
  logic       mem_ready;
  logic       MARin;
  logic       MDRin;
  logic       read;
  logic       mem_rd;
  logic       mem_wr;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] last_wait;

  int errors = 0;
  int checks = 0;

  mem_xfer_ctrl #(.WAIT_W(4), .MAX_WAIT(15)) dut (
    .clk(clk), .clr(clr),
    .req_rd(req_rd), .req_wr(req_wr),
    .mem_ready(mem_ready),
    .MARin(MARin), .MDRin(MDRin), .read(read),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .busy(busy), .done(done), .err(err),
    .last_wait(last_wait)
  );

  always #5 clk = ~clk;

  // Cycle n begins at edge n-1; observe 2 time units after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Outputs packed as {MARin,MDRin,read,mem_rd,mem_wr,busy,done,err}.
  function automatic logic [7:0] outs();
    return {MARin, MDRin, read, mem_rd, mem_wr, busy, done, err};
  endfunction

  task automatic test_reset();
    clr = 1'b0;
    req_rd = 1'b0;
    req_wr = 1'b0;
    mem_ready = 1'b0;
    tick();
    checks++;
    if (outs() !== 8'h00 || last_wait !== 4'd0) begin
      errors++;
      $display("FAIL reset: outs=%b lw=%0d want 00000000 lw=0",
               outs(), last_wait);
    end
    clr = 1'b1;
    tick();
    checks++;
    if (outs() !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle: outs=%b want 00000000", outs());
    end
  endtask

  task automatic test_read();
    mem_ready = 1'b1;
    req_rd = 1'b1;
    tick();
    req_rd = 1'b0;
    checks++;
    if (outs() !== 8'b1000_0100) begin
      errors++;
      $display("FAIL rd_mar: outs=%b want 10000100", outs());
    end
    tick();
    checks++;
    if (outs() !== 8'b0111_0100) begin
      errors++;
      $display("FAIL rd_wait: outs=%b want 01110100", outs());
    end
    tick();
    checks++;
    if (outs() !== 8'b0000_0010) begin
      errors++;
      $display("FAIL rd_done: outs=%b want 00000010", outs());
    end
    tick();
    checks++;
    if (outs() !== 8'h00 || last_wait !== 4'd0) begin
      errors++;
      $display("FAIL rd_idle: outs=%b lw=%0d want 00000000 lw=0",
               outs(), last_wait);
    end
  endtask

  task automatic test_write_waits();
    int rd_seen = 0;
    mem_ready = 1'b0;
    req_wr = 1'b1;
    tick();
    req_wr = 1'b0;
    checks++;
    if (outs() !== 8'b1000_0100) begin
      errors++;
      $display("FAIL wr_mar: outs=%b want 10000100", outs());
    end
    tick();
    checks++;
    if (outs() !== 8'b0100_0100) begin
      errors++;
      $display("FAIL wr_mdr: outs=%b want 01000100", outs());
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (outs() !== 8'b0000_1100) begin
        errors++;
        $display("FAIL wr_wait%0d: outs=%b want 00001100", i, outs());
      end
      if (mem_rd) rd_seen++;
      if (i == 3) mem_ready = 1'b1;
    end
    tick();
    checks++;
    if (outs() !== 8'b0000_0010) begin
      errors++;
      $display("FAIL wr_done: outs=%b want 00000010", outs());
    end
    tick();
    checks++;
    if (last_wait !== 4'd3 || busy !== 1'b0 || rd_seen != 0) begin
      errors++;
      $display("FAIL wr_lastwait: lw=%0d busy=%b rd=%0d want 3 0 0",
               last_wait, busy, rd_seen);
    end
  endtask

  task automatic test_priority();
    int wr_seen = 0;
    mem_ready = 1'b1;
    req_rd = 1'b1;
    req_wr = 1'b1;
    tick();
    req_rd = 1'b0;
    req_wr = 1'b0;
    if (mem_wr) wr_seen++;
    tick();
    if (mem_wr) wr_seen++;
    checks++;
    if (mem_rd !== 1'b1 || read !== 1'b1) begin
      errors++;
      $display("FAIL prio_rd: mem_rd=%b read=%b want 1 1", mem_rd, read);
    end
    tick();
    if (mem_wr) wr_seen++;
    checks++;
    if (done !== 1'b1 || wr_seen != 0) begin
      errors++;
      $display("FAIL prio_done: done=%b wr=%0d want 1 0", done, wr_seen);
    end
    tick();
  endtask

  task automatic test_clr_mid();
    mem_ready = 1'b0;
    req_rd = 1'b1;
    tick();
    req_rd = 1'b0;
    tick();
    tick();
    checks++;
    if (mem_rd !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clr_pre: mem_rd=%b busy=%b want 1 1", mem_rd, busy);
    end
    clr = 1'b0;
    #1;
    checks++;
    if (outs() !== 8'h00 || last_wait !== 4'd0) begin
      errors++;
      $display("FAIL clr_async: outs=%b lw=%0d want 00000000 lw=0",
               outs(), last_wait);
    end
    mem_ready = 1'b1;
    tick();
    clr = 1'b1;
    tick();
    checks++;
    if (outs() !== 8'h00) begin
      errors++;
      $display("FAIL clr_release: outs=%b want 00000000", outs());
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] done_v = '0;
    logic [8:0] mar_v = '0;
    int wide = 0;
    mem_ready = 1'b1;
    req_rd = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      done_v[i] = done;
      mar_v[i] = MARin;
      if (i > 0 && done && done_v[i-1]) wide++;
      if (i == 6) req_rd = 1'b0;
    end
    checks++;
    if (done_v !== 9'b0_0100_0100 || wide != 0) begin
      errors++;
      $display("FAIL b2b_done: got=%b want 001000100", done_v);
    end
    checks++;
    if (mar_v !== 9'b0_0001_0001) begin
      errors++;
      $display("FAIL b2b_mar: got=%b want 000010001", mar_v);
    end
  endtask

`ifdef MEM_XFER_TIMEOUT_EN
  task automatic test_timeout();
    int err_cnt = 0;
    int err_at = 0;
    int mdr_cnt = 0;
    mem_ready = 1'b0;
    req_rd = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      req_rd = 1'b0;
      if (err) begin
        err_cnt++;
        err_at = c;
      end
      if (MDRin) mdr_cnt++;
    end
    checks++;
    if (err_cnt != 1 || err_at != 18 || mdr_cnt != 0) begin
      errors++;
      $display("FAIL timeout: errs=%0d at=%0d mdr=%0d want 1 18 0",
               err_cnt, err_at, mdr_cnt);
    end
    checks++;
    if (last_wait !== 4'd15 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_lw: lw=%0d busy=%b want 15 0",
               last_wait, busy);
    end
  endtask
`else
  task automatic test_saturate();
    int err_cnt = 0;
    int idle_cnt = 0;
    mem_ready = 1'b0;
    req_rd = 1'b1;
    tick();
    req_rd = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (err) err_cnt++;
      if (!mem_rd || !busy) idle_cnt++;
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if (done !== 1'b1 || err_cnt != 0 || idle_cnt != 0) begin
      errors++;
      $display("FAIL sat_wait: done=%b err=%0d drop=%0d want 1 0 0",
               done, err_cnt, idle_cnt);
    end
    tick();
    checks++;
    if (last_wait !== 4'd15) begin
      errors++;
      $display("FAIL sat_lw: lw=%0d want 15", last_wait);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write_waits();
    test_priority();
    test_clr_mid();
    test_back_to_back();
`ifdef MEM_XFER_TIMEOUT_EN
    test_timeout();
`else
    test_saturate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
